// File: rtl/xmtbuffer.sv
// rtl/xmtbuffer.sv - loopback bit stream to byte FIFO to RS-232 holding register
//
// Purpose: assembles the serial loopback `databit` stream (sampled on falling
// edges of the synchronized clk_1200, LSB first) into bytes, queues them in a
// DEPTH-entry FIFO and drains the FIFO into the transmitter holding register
// with a load/busy handshake.
//
// Ports:
//   xmtbuf_clk  in   block clock, rising edge
//   rst         in   synchronous active-high reset
//   clk_1200    in   asynchronous 1200 Hz bit clock (2-flop synchronized)
//   databit     in   serial loopback data (2-flop synchronized)
//   loop_en     in   loopback bits valid; low discards any partial byte
//   tx_busy     in   transmitter busy
//   thr         out  byte for the transmitter holding register
//   thr_load    out  one-cycle load strobe for thr
//   fifo_count  out  bytes queued
//   fifo_empty  out  fifo_count == 0
//   overflow    out  sticky: a completed byte was dropped on a full FIFO
//
// Build option: define XMTBUF_TIMEOUT_EN to abandon a load when tx_busy has not
// risen within TIMEOUT cycles; the popped byte is then lost.

module xmtbuffer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              xmtbuf_clk,
  input  logic              rst,
  input  logic              clk_1200,
  input  logic              databit,
  input  logic              loop_en,
  input  logic              tx_busy,
  output logic [7:0]        thr,
  output logic              thr_load,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_empty,
  output logic              overflow
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;

  logic              ck_s1, ck_s2, ck_prev;
  logic              d_s1, d_s2;
  logic [2:0]        bit_cnt;
  logic [7:0]        sh;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  logic       sample, byte_done, full, push, pop;
  logic [7:0] new_byte;

  // A sample is the falling edge of the synchronized bit clock; databit was
  // launched on the rising edge, so it is settled by then.
  assign sample    = ck_prev & ~ck_s2;
  assign new_byte  = {d_s2, sh[7:1]};
  assign byte_done = sample & loop_en & (bit_cnt == 3'd7);
  assign full      = (fifo_count == FULL);
  assign push      = byte_done & ~full;
  // LOAD is only entered with a non-empty FIFO, so pop never underflows.
  assign pop       = (state == LOAD);
  assign fifo_empty = (fifo_count == '0);

  // Synchronizers and byte assembly
  always_ff @(posedge xmtbuf_clk) begin
    if (rst) begin
      ck_s1   <= 1'b0;
      ck_s2   <= 1'b0;
      ck_prev <= 1'b0;
      d_s1    <= 1'b0;
      d_s2    <= 1'b0;
      bit_cnt <= 3'd0;
      sh      <= 8'h00;
    end else begin
      ck_s1   <= clk_1200;
      ck_s2   <= ck_s1;
      ck_prev <= ck_s2;
      d_s1    <= databit;
      d_s2    <= d_s1;
      if (!loop_en) begin
        bit_cnt <= 3'd0;
        sh      <= 8'h00;
      end else if (sample) begin
        sh      <= new_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // FIFO storage needs no reset; only pointers and count define validity.
  always_ff @(posedge xmtbuf_clk) begin
    if (push) mem[wr_ptr] <= new_byte;
  end

  always_ff @(posedge xmtbuf_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
      if (byte_done && full) overflow <= 1'b1;
    end
  end

`ifdef XMTBUF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // Drain FSM with registered thr/thr_load
  always_ff @(posedge xmtbuf_clk) begin
    if (rst) begin
      state    <= IDLE;
      thr      <= 8'h00;
      thr_load <= 1'b0;
`ifdef XMTBUF_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      thr_load <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty && !tx_busy) state <= LOAD;
        end
        LOAD: begin
          thr      <= mem[rd_ptr];
          thr_load <= 1'b1;
          state    <= WAIT_BUSY;
`ifdef XMTBUF_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
        end
        WAIT_BUSY: begin
`ifdef XMTBUF_TIMEOUT_EN
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`else
          if (tx_busy) state <= WAIT_DONE;
`endif
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xmtbuffer.sv
// tb/tb_xmtbuffer.sv - self-checking bench for xmtbuffer

module tb_xmtbuffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1200 = 1'b0;
  logic       databit = 1'b0;
  logic       loop_en = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] thr;
  logic       thr_load;
  logic [4:0] fifo_count;
  logic       fifo_empty;
  logic       overflow;

  always #5 clk = ~clk;

  xmtbuffer #(.DEPTH(DEPTH), .ADDR_W(4), .TIMEOUT(64)) dut (
    .xmtbuf_clk (clk),
    .rst        (rst),
    .clk_1200   (clk_1200),
    .databit    (databit),
    .loop_en    (loop_en),
    .tx_busy    (tx_busy),
    .thr        (thr),
    .thr_load   (thr_load),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  int errors = 0;
  int checks = 0;

  // Model: bytes accepted into the FIFO, in order, not yet loaded.
  logic [7:0] model_q[$];
  bit         model_ovf = 0;
  logic [7:0] mbyte = 8'h00;
  int         mcnt = 0;

  int         loads = 0;
  logic [7:0] last_thr = 8'h00;
  int         cyc = 0;
  int         last_load_cyc = -1;
  int         last_gap = 0;
  bit         saw_load = 0;
  bit         tx_hold = 0;
  bit         tx_dead = 0;
  int         busy_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_load_cyc = -1;
    end else begin
      check("empty_flag", int'(fifo_empty), int'(fifo_count == 0));
      if (thr_load) begin
        saw_load = 1;
        if (model_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got thr=0x%0h expected no load", thr);
        end else begin
          check("thr_order", int'(thr), int'(model_q.pop_front()));
        end
        check("load_while_busy", int'(tx_busy), 0);
        if (last_load_cyc >= 0) begin
          last_gap = cyc - last_load_cyc;
          check("load_spacing_ge4", int'(last_gap >= 4), 1);
        end
        last_load_cyc = cyc;
        loads++;
        last_thr = thr;
      end
    end
  end

  // Transmitter model: busy for 20 cycles after each load
  initial begin
    forever begin
      bit take;
      @(posedge clk);
      #1;
      take = saw_load;
      saw_load = 0;
      if (tx_hold) begin
        tx_busy = 1'b1;
        busy_cnt = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end else if (take && !tx_dead) begin
        tx_busy = 1'b1;
        busy_cnt = 20;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_bit(input bit b);
    if (loop_en) begin
      mbyte = {b, mbyte[7:1]};
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        if (model_q.size() < DEPTH) model_q.push_back(mbyte);
        else model_ovf = 1;
      end
    end
  endtask

  task automatic send_bit(input bit b);
    clk_1200 = 1'b1;
    databit  = b;
    wait_clk(4);
    clk_1200 = 1'b0;
    model_bit(b);
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    model_q.delete();
    mcnt = 0;
    mbyte = 8'h00;
    model_ovf = 0;
  endtask

  task automatic check_reset_values();
    check("rst_thr", int'(thr), 0);
    check("rst_thr_load", int'(thr_load), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_fifo_empty", int'(fifo_empty), 1);
    check("rst_overflow", int'(overflow), 0);
  endtask

  initial begin
    int n;
    int l0;
    logic [7:0] v;

    // Reset state
    do_reset();
    check_reset_values();

    // Single byte 0xA5 (bits 1,0,1,0,0,1,0,1) and drain latency
    loop_en = 1'b1;
    v = 8'hA5;
    l0 = loads;
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    clk_1200 = 1'b1;
    databit  = v[7];
    wait_clk(4);
    clk_1200 = 1'b0;
    model_bit(v[7]);
    n = 0;
    while (!thr_load && n < 20) begin
      wait_clk(1);
      n++;
    end
    // 2 sync stages + sample edge, then IDLE and LOAD: strobe after the 5th edge
    check("load_latency", n, 5);
    wait_clk(40);
    check("single_thr", int'(thr), 8'hA5);
    check("single_loads", loads - l0, 1);
    check("single_count", int'(fifo_count), 0);

    // Handshake: three bytes queued behind a busy transmitter
    tx_hold = 1;
    wait_clk(2);
    l0 = loads;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    wait_clk(8);
    check("hs_count", int'(fifo_count), 3);
    check("hs_no_load", loads - l0, 0);
    tx_hold = 0;
    wait_clk(150);
    check("hs_loads", loads - l0, 3);
    check("hs_last_thr", int'(last_thr), 8'h03);
    check("hs_count_end", int'(fifo_count), 0);

    // Overflow: 17 bytes into a stalled transmitter
    tx_hold = 1;
    wait_clk(2);
    l0 = loads;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'(8'h10 + i));
    wait_clk(8);
    check("ovf_count", int'(fifo_count), 16);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_model", int'(model_ovf), 1);
    tx_hold = 0;
    wait_clk(700);
    check("ovf_loads", loads - l0, 16);
    check("ovf_last_thr", int'(last_thr), 8'h1F);
    check("ovf_sticky", int'(overflow), 1);

    // Partial byte discarded by a one-cycle loop_en drop
    l0 = loads;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    loop_en = 1'b0;
    mcnt = 0;
    mbyte = 8'h00;
    wait_clk(1);
    loop_en = 1'b1;
    send_byte(8'h3C);
    wait_clk(40);
    check("partial_loads", loads - l0, 1);
    check("partial_thr", int'(last_thr), 8'h3C);

    // Reset mid-stream with a queued byte and a partial byte
    tx_hold = 1;
    wait_clk(2);
    send_byte(8'h77);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_reset();
    check_reset_values();
    l0 = loads;
    tx_hold = 0;
    wait_clk(40);
    check("post_rst_no_load", loads - l0, 0);
    send_byte(8'h5A);
    wait_clk(40);
    check("post_rst_loads", loads - l0, 1);
    check("post_rst_thr", int'(last_thr), 8'h5A);

`ifdef XMTBUF_TIMEOUT_EN
    // Transmitter never goes busy: each load is abandoned after TIMEOUT cycles
    tx_hold = 1;
    wait_clk(2);
    l0 = loads;
    send_byte(8'h11);
    send_byte(8'h22);
    wait_clk(8);
    tx_dead = 1;
    tx_hold = 0;
    wait_clk(250);
    check("tmo_loads", loads - l0, 2);
    check("tmo_gap", last_gap, 66);
    check("tmo_last_thr", int'(last_thr), 8'h22);
    check("tmo_count", int'(fifo_count), 0);
    tx_dead = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
